// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the digit-serial subtractor.
// FSM state encoding plus default operand and digit widths.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIGIT = 1;

endpackage

// File: rtl/digit_subtractor.sv
// Combinational W-bit ripple-borrow slice.
// Chain of full-subtractor cells, LSB first.
module digit_subtractor
  import serial_sub_pkg::*;
#(
  parameter int W = DEF_DIGIT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bi,
  output logic [W-1:0] diff,
  output logic         bo
);

  logic [W:0] br;

  assign br[0] = bi;

  for (genvar i = 0; i < W; i++) begin : g_cell
    assign diff[i]  = a[i] ^ b[i] ^ br[i];
    assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end

  assign bo = br[W];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial x - y - bin with valid/ready handshakes.
// Optional overflow port: SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             busy
);

  localparam int NSTEP = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  if (DIGIT < 1) begin : g_bad_digit
    $error("serial_subtractor: DIGIT must be >= 1");
  end else if ((WIDTH % DIGIT) != 0) begin : g_bad_width
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
  end

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic              brw_q, brw_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic              bout_q, bout_d;
  logic [WIDTH-1:0]  res;
  logic [DIGIT-1:0]  s_diff;
  logic              s_bo;
  int                idx;

  assign idx = int'(cnt_q) * DIGIT;

  digit_subtractor #(
    .W (DIGIT)
  ) u_slice (
    .a    (x_q[idx +: DIGIT]),
    .b    (y_q[idx +: DIGIT]),
    .bi   (brw_q),
    .diff (s_diff),
    .bo   (s_bo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    brw_d   = brw_q;
    acc_d   = acc_q;
    d_d     = d_q;
    bout_d  = bout_q;
    res     = acc_q;
    res[idx +: DIGIT] = s_diff;
    unique case (1'b1)
      state_q == IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
          x_d     = x;
          y_d     = y;
          brw_d   = bin;
        end
      end
      state_q == RUN: begin
        acc_d = res;
        brw_d = s_bo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          d_d     = res;
          bout_d  = s_bo;
        end
      end
      state_q == DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      brw_q   <= 1'b0;
      acc_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      brw_q   <= brw_d;
      acc_q   <= acc_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // Same as borrow-into-MSB ^ bout: operand signs differ and result sign flips.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && cnt_q == LAST)
      ovf_d = (x_q[WIDTH-1] ^ y_q[WIDTH-1]) & (x_q[WIDTH-1] ^ res[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign d         = d_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: DIGIT=1 and DIGIT=4 instances vs arithmetic model.
// Define SERIAL_SUBTRACTOR_OVERFLOW_EN to also check the overflow port.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       iv[2];
  logic       ir[2];
  logic       ov[2];
  logic       ors[2];
  logic       bs[2];
  logic       bos[2];
  logic       by[2];
  logic [7:0] xs[2];
  logic [7:0] ys[2];
  logic [7:0] ds[2];
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic       ovf[2];
`endif

  int nvec = 0;
  int nerr = 0;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv[0]),
    .in_ready  (ir[0]),
    .x         (xs[0]),
    .y         (ys[0]),
    .bin       (bs[0]),
    .out_valid (ov[0]),
    .out_ready (ors[0]),
    .d         (ds[0]),
    .bout      (bos[0]),
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    .overflow  (ovf[0]),
`endif
    .busy      (by[0])
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv[1]),
    .in_ready  (ir[1]),
    .x         (xs[1]),
    .y         (ys[1]),
    .bin       (bs[1]),
    .out_valid (ov[1]),
    .out_ready (ors[1]),
    .d         (ds[1]),
    .bout      (bos[1]),
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    .overflow  (ovf[1]),
`endif
    .busy      (by[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b,
                                         input logic c);
    int r;
    r = int'(a) - int'(b) - int'(c);
    return {r < 0, 8'(r)};
  endfunction

  function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b,
                                   input logic c);
    int r;
    r = int'($signed(a)) - int'($signed(b)) - int'(c);
    return (r < -128) || (r > 127);
  endfunction

  function automatic int lat_exp(input int s);
    return (s == 0) ? 8 / 1 + 1 : 8 / 4 + 1;
  endfunction

  task automatic run_op(input int s, input logic [7:0] xv, input logic [7:0] yv,
                        input logic bv, output logic [7:0] dv, output logic bov,
                        output int lat);
    @(negedge clk);
    xs[s] = xv; ys[s] = yv; bs[s] = bv;
    iv[s] = 1'b1; ors[s] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      iv[s] = 1'b0;
      xs[s] = 8'($urandom);
      ys[s] = 8'($urandom);
      bs[s] = 1'($urandom);
    end while (ov[s] !== 1'b1 && lat < 40);
    if (ov[s] !== 1'b1) lat = -1;
    dv  = ds[s];
    bov = bos[s];
  endtask

  task automatic release_op(input int s);
    ors[s] = 1'b1;
    @(negedge clk);
    ors[s] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; ors[s] = 1'b0; bs[s] = 1'b0;
      xs[s] = '0; ys[s] = '0;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      nvec++;
      if ({ds[s], bos[s], ov[s], by[s]} !== 11'd0) begin
        nerr++;
        $display("FAIL reset_outs[%0d] got d=%h bo=%b ov=%b busy=%b want 0",
                 s, ds[s], bos[s], ov[s], by[s]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      nvec++;
      if (ir[s] !== 1'b1) begin
        nerr++;
        $display("FAIL reset_ready[%0d] got %b want 1", s, ir[s]);
      end
    end
  endtask

  task automatic test_directed;
    logic [7:0] xv[4] = '{8'h05, 8'h00, 8'h00, 8'hA7};
    logic [7:0] yv[4] = '{8'h03, 8'h01, 8'h00, 8'h5C};
    logic       bv[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] dw[4] = '{8'h02, 8'hFF, 8'hFF, 8'h4B};
    logic       bw[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int         sv[4] = '{0, 0, 0, 1};
    logic [7:0] dv;
    logic       bov;
    int         lat;
    for (int i = 0; i < 4; i++) begin
      run_op(sv[i], xv[i], yv[i], bv[i], dv, bov, lat);
      nvec++;
      if (lat != lat_exp(sv[i])) begin
        nerr++;
        $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, lat_exp(sv[i]));
      end
      nvec++;
      if ({bov, dv} !== {bw[i], dw[i]}) begin
        nerr++;
        $display("FAIL dir_result[%0d] got bo=%b d=%h want bo=%b d=%h",
                 i, bov, dv, bw[i], dw[i]);
      end
      release_op(sv[i]);
    end
  endtask

  task automatic test_random;
    logic [7:0] xv, yv, dv;
    logic       bv, bov;
    logic [8:0] exp;
    int         s, lat;
    for (int i = 0; i < 24; i++) begin
      s  = int'($urandom_range(1, 0));
      xv = 8'($urandom);
      yv = 8'($urandom);
      bv = 1'($urandom);
      exp = ref_sub(xv, yv, bv);
      run_op(s, xv, yv, bv, dv, bov, lat);
      nvec++;
      if ({bov, dv} !== exp || lat != lat_exp(s)) begin
        nerr++;
        $display("FAIL rand[%0d] s=%0d %h-%h-%b got bo=%b d=%h lat=%0d want %h lat=%0d",
                 i, s, xv, yv, bv, bov, dv, lat, exp, lat_exp(s));
      end
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      nvec++;
      if (ovf[s] !== ref_ovf(xv, yv, bv)) begin
        nerr++;
        $display("FAIL rand_ovf[%0d] got %b want %b", i, ovf[s], ref_ovf(xv, yv, bv));
      end
`endif
      release_op(s);
    end
  endtask

  task automatic test_hold;
    logic [7:0] dv;
    logic       bov;
    logic [8:0] exp;
    int         lat;
    exp = ref_sub(8'h3C, 8'h71, 1'b1);
    run_op(0, 8'h3C, 8'h71, 1'b1, dv, bov, lat);
    for (int k = 0; k < 5; k++) begin
      iv[0] = 1'b1;
      xs[0] = 8'($urandom);
      @(negedge clk);
      nvec++;
      if ({ov[0], ir[0], bos[0], ds[0]} !== {1'b1, 1'b0, exp}) begin
        nerr++;
        $display("FAIL hold[%0d] got ov=%b rdy=%b bo=%b d=%h want 1 0 %h",
                 k, ov[0], ir[0], bos[0], ds[0], exp);
      end
    end
    iv[0] = 1'b0;
    release_op(0);
    nvec++;
    if ({ov[0], ir[0], by[0]} !== 3'b010) begin
      nerr++;
      $display("FAIL hold_exit got ov=%b rdy=%b busy=%b want 0 1 0", ov[0], ir[0], by[0]);
    end
    @(negedge clk);
    nvec++;
    if (ds[0] !== exp[7:0]) begin
      nerr++;
      $display("FAIL d_retained got %h want %h", ds[0], exp[7:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] dv;
    logic       bov;
    logic [8:0] exp;
    int         lat;
    run_op(1, 8'h10, 8'h20, 1'b0, dv, bov, lat);
    exp = ref_sub(8'hE4, 8'h19, 1'b1);
    xs[1] = 8'hE4; ys[1] = 8'h19; bs[1] = 1'b1;
    iv[1] = 1'b1; ors[1] = 1'b1;
    @(negedge clk);
    ors[1] = 1'b0;
    nvec++;
    if ({ov[1], by[1], ir[1]} !== 3'b001) begin
      nerr++;
      $display("FAIL b2b_no_accept got ov=%b busy=%b rdy=%b want 0 0 1", ov[1], by[1], ir[1]);
    end
    @(negedge clk);
    iv[1] = 1'b0;
    nvec++;
    if (by[1] !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_accept got busy=%b want 1", by[1]);
    end
    lat = 0;
    while (ov[1] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    nvec++;
    if (ov[1] !== 1'b1 || {bos[1], ds[1]} !== exp) begin
      nerr++;
      $display("FAIL b2b_result got ov=%b bo=%b d=%h want 1 %h", ov[1], bos[1], ds[1], exp);
    end
    release_op(1);
  endtask

  task automatic test_async_reset;
    logic [7:0] dv;
    logic       bov;
    int         lat;
    int         seen;
    @(negedge clk);
    xs[0] = 8'h9A; ys[0] = 8'h21; bs[0] = 1'b0; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    nvec++;
    if ({ds[0], bos[0], ov[0], by[0]} !== 11'd0) begin
      nerr++;
      $display("FAIL async_rst got d=%h bo=%b ov=%b busy=%b want 0",
               ds[0], bos[0], ov[0], by[0]);
    end
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    nvec++;
    if (ovf[0] !== 1'b0) begin
      nerr++;
      $display("FAIL async_rst_ovf got %b want 0", ovf[0]);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov[0] === 1'b1) seen++;
    end
    nvec++;
    if (seen != 0) begin
      nerr++;
      $display("FAIL async_rst_discard got %0d out_valid cycles want 0", seen);
    end
    run_op(0, 8'h44, 8'h45, 1'b0, dv, bov, lat);
    nvec++;
    if ({bov, dv} !== ref_sub(8'h44, 8'h45, 1'b0) || lat != lat_exp(0)) begin
      nerr++;
      $display("FAIL post_rst got bo=%b d=%h lat=%0d want %h lat=%0d",
               bov, dv, lat, ref_sub(8'h44, 8'h45, 1'b0), lat_exp(0));
    end
    release_op(0);
  endtask

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  task automatic test_overflow;
    logic [7:0] dv;
    logic       bov;
    int         lat;
    run_op(0, 8'h80, 8'h01, 1'b0, dv, bov, lat);
    nvec++;
    if ({ovf[0], bov, dv} !== {1'b1, 1'b0, 8'h7F}) begin
      nerr++;
      $display("FAIL ovf_80_01 got ovf=%b bo=%b d=%h want 1 0 7f", ovf[0], bov, dv);
    end
    release_op(0);
    run_op(1, 8'h05, 8'h03, 1'b0, dv, bov, lat);
    nvec++;
    if ({ovf[1], bov, dv} !== {1'b0, 1'b0, 8'h02}) begin
      nerr++;
      $display("FAIL ovf_05_03 got ovf=%b bo=%b d=%h want 0 0 02", ovf[1], bov, dv);
    end
    release_op(1);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_async_reset();
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    test_overflow();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
